pipe_adder: RTL and testbench

- Parametrised, pipelined successor to the team's 8-bit combinational adder.
- Generalised width; ADD/SUB/ACCUMULATE/CLEAR modes; carry/borrow and signed-overflow flags; optional unsigned saturation.
- Valid/ready handshake on both sides, two-cycle latency, full throughput.
- Sits between a stimulus/driver-side producer and a result consumer (scoreboard/monitor-visible).

---
 rtl/pipe_adder_pkg.sv | 13 +
 rtl/pipe_adder_add_core.sv | 27 ++
 rtl/pipe_adder.sv | 118 +++++++++++
 tb/tb_pipe_adder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared opcode encoding for the pipelined adder and its arithmetic core.
package pipe_adder_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

endpackage

// File: rtl/pipe_adder_add_core.sv
// Combinational add/subtract with carry/borrow, signed overflow and optional
// unsigned saturation. Flags always describe the unsaturated result.
module add_core #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] raw;

  always_comb begin
    // Top bit of the (WIDTH+1)-bit difference is the unsigned borrow.
    raw      = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    carry    = raw[WIDTH];
    overflow = (sub ? (x[WIDTH-1] != y[WIDTH-1]) : (x[WIDTH-1] == y[WIDTH-1]))
               && (raw[WIDTH-1] != x[WIDTH-1]);
    res      = raw[WIDTH-1:0];
    if (SAT_EN && carry) res = sub ? '0 : '1;
  end

endmodule

// File: rtl/pipe_adder.sv
// Two-stage valid/ready adder: stage 1 captures operands, stage 2 computes
// against the accumulator and holds the result until the consumer takes it.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
  } s1_t;

  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] acc_q;

  logic             s1_adv;
  logic             s2_load;
  logic             in_fire;

  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic             core_sub;
  logic [WIDTH-1:0] core_res;
  logic             core_c;
  logic             core_o;

  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;

  // in_ready is forced low while reset is held, not just after the flops clear.
  always_comb begin
    s1_adv   = !s2_valid || out_ready;
    in_ready = !rstn && (!s1_valid || s1_adv);
    in_fire  = in_valid && in_ready;
    s2_load  = s1_valid && s1_adv;
  end

  always_comb begin
    core_x   = (s1_q.op == OP_ACC) ? acc_q : s1_q.a;
    core_y   = (s1_q.op == OP_ACC) ? s1_q.a : s1_q.b;
    core_sub = (s1_q.op == OP_SUB);
    res_d    = core_res;
    carry_d  = core_c;
    ovf_d    = core_o;
    if (s1_q.op == OP_CLR) begin
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  add_core #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_core (
    .x        (core_x),
    .y        (core_y),
    .sub      (core_sub),
    .res      (core_res),
    .carry    (core_c),
    .overflow (core_o)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_q     <= '{a: a, b: b, op: op_e'(op)};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // acc updates in the same edge the transaction enters stage 2, so a
  // following ACC already in stage 1 sees the new value without a bubble.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      acc_q    <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      sum      <= res_d;
      carry    <= carry_d;
      overflow <= ovf_d;
      if (s1_q.op == OP_ACC) acc_q <= res_d;
      else if (s1_q.op == OP_CLR) acc_q <= '0;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and randomised checks of pipe_adder, wrap-around and saturating
// instances driven in lockstep.
module tb_pipe_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0]   op = '0;

  logic         in_ready, out_valid, carry, overflow;
  logic [W-1:0] sum;
  logic         in_ready_s, out_valid_s, carry_s, overflow_s;
  logic [W-1:0] sum_s;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
    logic [7:0] ss;
    logic       cs;
    logic       os;
  } out_t;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } res_t;

  out_t       obs[$];
  out_t       exp_q[$];
  logic [7:0] m_acc = '0, m_acc_s = '0;

  pipe_adder #(.WIDTH(W), .SAT_EN(1'b0)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow));

  pipe_adder #(.WIDTH(W), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .op(op), .out_valid(out_valid_s), .out_ready(out_ready),
    .sum(sum_s), .carry(carry_s), .overflow(overflow_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic out_t mk(input logic [7:0] s, input logic c, input logic o,
                              input logic [7:0] ss, input logic cs, input logic os);
    mk = '{s: s, c: c, o: o, ss: ss, cs: cs, os: os};
  endfunction

  // Integer reference: carry from unsigned range, overflow from signed range.
  function automatic res_t calc(input logic [7:0] x, input logic [7:0] y,
                                input bit sub, input bit sat);
    int ux, uy, sx, sy, u, s;
    res_t r;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    u = sub ? ux - uy : ux + uy;
    s = sub ? sx - sy : sx + sy;
    r.c = sub ? (ux < uy) : (u > 255);
    r.o = (s > 127) || (s < -128);
    r.s = u[7:0];
    if (sat && r.c) r.s = sub ? 8'h00 : 8'hFF;
    return r;
  endfunction

  always @(negedge clk) begin
    res_t r, rs;
    if (rstn) begin
      m_acc = '0;
      m_acc_s = '0;
    end else begin
      if (out_valid && out_ready)
        obs.push_back(mk(sum, carry, overflow, sum_s, carry_s, overflow_s));
      if (in_valid && in_ready) begin
        case (op)
          2'b00: begin r = calc(a, b, 1'b0, 1'b0); rs = calc(a, b, 1'b0, 1'b1); end
          2'b01: begin r = calc(a, b, 1'b1, 1'b0); rs = calc(a, b, 1'b1, 1'b1); end
          2'b10: begin
            r = calc(m_acc, a, 1'b0, 1'b0);
            rs = calc(m_acc_s, a, 1'b0, 1'b1);
            m_acc = r.s;
            m_acc_s = rs.s;
          end
          default: begin r = '0; rs = '0; m_acc = '0; m_acc_s = '0; end
        endcase
        exp_q.push_back(mk(r.s, r.c, r.o, rs.s, rs.c, rs.o));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top);
    bit hs = 1'b0;
    int n = 0;
    in_valid = 1'b1; a = ta; b = tb; op = top;
    while (!hs && n < 100) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    total++;
    if (!hs) begin bad++; $display("FAIL send_timeout got=not_accepted exp=accepted"); end
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (obs.size() < n && k < 200) begin @(posedge clk); #1; k++; end
    total++;
    if (obs.size() < n) begin
      bad++; $display("FAIL out_timeout got=%0d exp=%0d", obs.size(), n);
    end
  endtask

  task automatic settle_empty(input string name);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (obs.size() != 0) begin
      bad++; $display("FAIL %s_extra got=%0d exp=0", name, obs.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, sum, carry, overflow, in_ready_s, out_valid_s} !== '0) begin
      bad++;
      $display("FAIL reset_hold got=%b/%b/%h/%b/%b exp=0/0/00/0/0",
               in_ready, out_valid, sum, carry, overflow);
    end
    rstn = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release got=%b/%b exp=1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    out_t got;
    out_t ev[2];
    ev[0] = mk(8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    ev[1] = mk(8'h01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    obs.delete(); out_ready = 1'b1;
    send(8'h7F, 8'h01, 2'b00);
    send(8'hFF, 8'h02, 2'b00);
    wait_out(2);
    for (int i = 0; i < 2; i++) begin
      got = (obs.size() != 0) ? obs.pop_front() : '0;
      total++;
      if (got !== ev[i]) begin bad++; $display("FAIL add_%0d got=%h exp=%h", i, got, ev[i]); end
    end
  endtask

  task automatic test_sub();
    out_t got;
    out_t ev[2];
    ev[0] = mk(8'hFE, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    ev[1] = mk(8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    obs.delete(); out_ready = 1'b1;
    send(8'h05, 8'h07, 2'b01);
    send(8'h80, 8'h01, 2'b01);
    wait_out(2);
    for (int i = 0; i < 2; i++) begin
      got = (obs.size() != 0) ? obs.pop_front() : '0;
      total++;
      if (got !== ev[i]) begin bad++; $display("FAIL sub_%0d got=%h exp=%h", i, got, ev[i]); end
    end
  endtask

  task automatic test_back_to_back();
    out_t got;
    out_t ev[5];
    int c0;
    ev[0] = mk(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    ev[1] = mk(8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    ev[2] = mk(8'h30, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
    ev[3] = mk(8'h20, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    ev[4] = mk(8'h21, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
    obs.delete(); out_ready = 1'b1;
    c0 = cyc;
    send(8'h00, 8'h55, 2'b11);
    send(8'h10, 8'h55, 2'b10);
    send(8'h20, 8'h55, 2'b10);
    send(8'hF0, 8'h55, 2'b10);
    send(8'h01, 8'h55, 2'b10);
    total++;
    if (cyc - c0 != 5) begin bad++; $display("FAIL acc_throughput got=%0d exp=5", cyc - c0); end
    wait_out(5);
    for (int i = 0; i < 5; i++) begin
      got = (obs.size() != 0) ? obs.pop_front() : '0;
      total++;
      if (got !== ev[i]) begin bad++; $display("FAIL acc_%0d got=%h exp=%h", i, got, ev[i]); end
    end
  endtask

  task automatic test_backpressure();
    out_t got;
    out_t ev[5];
    logic [7:0] held;
    ev[0] = mk(8'h02, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    ev[1] = mk(8'h30, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
    ev[2] = mk(8'hFE, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b1);
    ev[3] = mk(8'hFE, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    ev[4] = mk(8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    obs.delete(); out_ready = 1'b0;
    fork
      begin
        send(8'h01, 8'h01, 2'b00);
        send(8'h10, 8'h20, 2'b00);
        send(8'h7F, 8'h7F, 2'b00);
        send(8'hFF, 8'hFF, 2'b00);
        send(8'h80, 8'h80, 2'b00);
      end
      begin
        repeat (3) @(posedge clk);
        #1; held = sum;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          bad++; $display("FAIL bp_stall got=%b/%b exp=0/1", in_ready, out_valid);
        end
        total++;
        if (sum !== held || sum !== 8'h02 || obs.size() != 0) begin
          bad++; $display("FAIL bp_hold got=%h/%h/%0d exp=02/02/0", held, sum, obs.size());
        end
        out_ready = 1'b1;
      end
    join
    wait_out(5);
    for (int i = 0; i < 5; i++) begin
      got = (obs.size() != 0) ? obs.pop_front() : '0;
      total++;
      if (got !== ev[i]) begin bad++; $display("FAIL bp_%0d got=%h exp=%h", i, got, ev[i]); end
    end
    settle_empty("bp");
  endtask

  task automatic test_reset_midstream();
    out_t got;
    obs.delete(); out_ready = 1'b1;
    send(8'h00, 8'h00, 2'b11);
    send(8'h10, 8'h00, 2'b10);
    send(8'h20, 8'h00, 2'b10);
    wait_out(3);
    obs.delete(); out_ready = 1'b0;
    send(8'h01, 8'h01, 2'b00);
    send(8'h02, 8'h02, 2'b00);
    #2 rstn = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_valid_s !== 1'b0) begin
      bad++; $display("FAIL rst_async got=%b/%b exp=0/0", out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_release got=%b/%b exp=1/0", in_ready, out_valid);
    end
    obs.delete(); exp_q.delete();
    send(8'h01, 8'h00, 2'b10);
    wait_out(1);
    got = (obs.size() != 0) ? obs.pop_front() : '0;
    total++;
    if (got !== mk(8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0)) begin
      bad++; $display("FAIL rst_acc got=%h exp=%h", got, mk(8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0));
    end
    settle_empty("rst");
  endtask

  task automatic test_random();
    out_t got, want;
    int sent = 0;
    int guard = 0;
    int nfail = 0;
    bit hs;
    @(posedge clk); #1;
    obs.delete(); exp_q.delete();
    while (sent < 10000 && guard < 80000) begin
      @(negedge clk); hs = in_valid && in_ready;
      @(posedge clk); #1; guard++;
      if (hs) sent++;
      if (!in_valid || hs) begin
        in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
        a = 8'($urandom); b = 8'($urandom);
        op = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (sent != 10000 || obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count got=%0d/%0d exp=10000/%0d", sent, obs.size(), exp_q.size());
    end
    while (obs.size() != 0 && exp_q.size() != 0) begin
      got = obs.pop_front();
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++; nfail++;
        if (nfail <= 20) $display("FAIL rand_item got=%h exp=%h", got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
